round_sequencer: RTL

Sequences one game round for the game controller datapath. It latches the difficulty level and loads a level-dependent countdown. It drives the controller's enable and time_out inputs and watches the 3-bit done flags for round completion. It also keeps a saturating score.

---
 rtl/round_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/round_sequencer.sv
// Game round sequencer: loads a level-dependent countdown, watches the
// datapath done flags for a win, and keeps a saturating score.
module round_sequencer #(
    parameter int TICK_DIV = 50000000,
    parameter int T_NORMAL = 30,
    parameter int T_INTER  = 20,
    parameter int T_ADV    = 10,
    parameter int TW       = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    level,
    input  logic [2:0]    done,
    output logic          enable,
    output logic          time_out,
    output logic [TW-1:0] secs_left,
    output logic          round_won,
    output logic          round_lost,
    output logic          busy,
    output logic [7:0]    score
);

    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PLAY = 3'd2,
        WIN  = 3'd3,
        LOSE = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] secs, secs_n;
    logic [PW-1:0] presc, presc_n;
    logic [7:0]    pts, score_n;
    logic [8:0]    sum;
    logic [1:0]    lvl, lvl_n;
    logic [TW-1:0] t_load;
    logic          tick;
    logic          go;

    always_comb begin
        t_load = TW'(T_NORMAL);
        pts    = 8'd1;
        case (lvl)
            2'b01: begin
                t_load = TW'(T_INTER);
                pts    = 8'd2;
            end
            2'b11: begin
                t_load = TW'(T_ADV);
                pts    = 8'd4;
            end
            default: ;
        endcase
    end

    assign sum  = {1'b0, score} + {1'b0, pts};
    assign tick = (presc == PW'(TICK_DIV - 1));
    assign go   = start && (level != 2'b10);

    always_comb begin
        state_n = state;
        secs_n  = secs;
        presc_n = presc;
        score_n = score;
        lvl_n   = lvl;
        case (state)
            IDLE, WIN, LOSE: begin
                if (go) begin
                    state_n = LOAD;
                    lvl_n   = level;
                end
            end
            LOAD: begin
                secs_n  = t_load;
                presc_n = '0;
                state_n = PLAY;
            end
            PLAY: begin
                presc_n = tick ? '0 : presc + PW'(1);
                // A win in the same cycle as expiry beats the timeout
                if (done == 3'b111) begin
                    state_n = WIN;
                    score_n = sum[8] ? 8'hFF : sum[7:0];
                end else if (tick) begin
                    if (secs != '0) secs_n = secs - TW'(1);
                    if (secs <= TW'(1)) state_n = LOSE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            secs  <= '0;
            presc <= '0;
            score <= 8'd0;
            lvl   <= 2'b00;
        end else begin
            state <= state_n;
            secs  <= secs_n;
            presc <= presc_n;
            score <= score_n;
            lvl   <= lvl_n;
        end
    end

    assign enable     = (state == PLAY);
    assign busy       = (state == LOAD) || (state == PLAY);
    assign time_out   = (state == LOSE);
    assign round_lost = (state == LOSE);
    assign round_won  = (state == WIN);
    assign secs_left  = secs;

endmodule
